// File: rtl/mips_bus_pkg.sv
// mips_bus_pkg
//   Shared types and constants for the MIPS instruction/data bus arbiter.
//   ADDR_W / DATA_W / BE_W : widths of the address, data and byte-enable buses
//   arb_state_t            : arbiter ownership state (idle, m0 owns, m1 owns)
//   GRANT_M0 / GRANT_M1    : encoding of the one-bit last_grant register
package mips_bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_M0   = 2'd1,
        ARB_M1   = 2'd2
    } arb_state_t;

    localparam logic GRANT_M0 = 1'b0;
    localparam logic GRANT_M1 = 1'b1;

endpackage

// File: rtl/mips_bus_rr_grant.sv
// mips_bus_rr_grant
//   Combinational next-grant selection for the two-master arbiter.
//   Parameter ROUND_ROBIN : 1 = on a tie grant the master that did not win
//                           last time, 0 = on a tie always grant m1 (data port).
//   req0, req1   in  : m0 / m1 currently requesting (read or write)
//   last_grant   in  : master that completed the most recent transfer
//   grant_valid  out : at least one master is requesting
//   grant        out : master to grant (GRANT_M0 / GRANT_M1)
module mips_bus_rr_grant
    import mips_bus_pkg::*;
#(
    parameter int ROUND_ROBIN = 1
) (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant
);

    always_comb begin
        // NOTE: every variable assigned in a combinational block gets a default
        // first, so no path through the block can infer a latch.
        grant_valid = req0 | req1;
        grant       = GRANT_M0;
        if (req0 && req1) begin
            if (ROUND_ROBIN != 0) begin
                grant = ~last_grant;
            end else begin
                grant = GRANT_M1;
            end
        end else if (req1) begin
            grant = GRANT_M1;
        end
    end

endmodule

// File: rtl/mips_bus_arbiter.sv
// mips_bus_arbiter
//   Arbitrates an instruction master (m0) and a data master (m1) onto a single
//   Avalon-style memory slave. A request seen in ARB_IDLE is granted on the
//   next edge; while a master owns the bus its signals pass straight through to
//   the slave. After every completed transfer the bus returns to ARB_IDLE for
//   one cycle before the next grant.
//
//   Parameter ROUND_ROBIN : 1 = round-robin tie-break, 0 = fixed priority to m1.
//   clk, reset                         : clock, asynchronous active-high reset
//   m0_* / m1_* address, read, write,
//        writedata, byteenable   (in)  : master requests, held until accepted
//   m0_* / m1_* waitrequest, readdata
//                               (out)  : per-master stall and read data
//   s_address, s_read, s_write,
//        s_writedata, s_byteenable (out): forwarded request to the slave
//   s_waitrequest, s_readdata     (in) : slave stall and read data
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int ROUND_ROBIN = 1
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic [BE_W-1:0]   m0_byteenable,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic [BE_W-1:0]   m1_byteenable,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,

    output logic [ADDR_W-1:0] s_address,
    output logic              s_read,
    output logic              s_write,
    output logic [DATA_W-1:0] s_writedata,
    output logic [BE_W-1:0]   s_byteenable,
    input  logic              s_waitrequest,
    input  logic [DATA_W-1:0] s_readdata
);

    arb_state_t state, state_next;
    logic       last_grant, last_grant_next;
    logic       req0, req1;
    logic       grant_valid, grant;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    mips_bus_rr_grant #(
        .ROUND_ROBIN (ROUND_ROBIN)
    ) u_rr_grant (
        .req0        (req0),
        .req1        (req1),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    // Reset favours m1 as the last winner so the first tie after reset goes to m0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ARB_IDLE;
            last_grant <= GRANT_M1;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // that were present before the edge, independent of statement order.
            state      <= state_next;
            last_grant <= last_grant_next;
        end
    end

    // Outputs decode from the registered state only, so reset idles the bus
    // at once without waiting for a clock edge.
    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;

        s_address       = '0;
        s_read          = 1'b0;
        s_write         = 1'b0;
        s_writedata     = '0;
        s_byteenable    = '0;
        m0_waitrequest  = 1'b1;
        m0_readdata     = '0;
        m1_waitrequest  = 1'b1;
        m1_readdata     = '0;

        unique case (state)
            ARB_IDLE: begin
                if (grant_valid) begin
                    state_next = (grant == GRANT_M1) ? ARB_M1 : ARB_M0;
                end
            end

            ARB_M0: begin
                s_address      = m0_address;
                // A simultaneous read and write is forwarded as a write only.
                s_read         = m0_read & ~m0_write;
                s_write        = m0_write;
                s_writedata    = m0_writedata;
                s_byteenable   = m0_byteenable;
                m0_waitrequest = s_waitrequest;
                m0_readdata    = s_readdata;
                if (!req0) begin
                    // Owner abandoned its request: release without crediting it.
                    state_next = ARB_IDLE;
                end else if (!s_waitrequest) begin
                    state_next      = ARB_IDLE;
                    last_grant_next = GRANT_M0;
                end
            end

            ARB_M1: begin
                s_address      = m1_address;
                s_read         = m1_read & ~m1_write;
                s_write        = m1_write;
                s_writedata    = m1_writedata;
                s_byteenable   = m1_byteenable;
                m1_waitrequest = s_waitrequest;
                m1_readdata    = s_readdata;
                if (!req1) begin
                    state_next = ARB_IDLE;
                end else if (!s_waitrequest) begin
                    state_next      = ARB_IDLE;
                    last_grant_next = GRANT_M1;
                end
            end

            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// tb_mips_bus_arbiter
//   Drives a round-robin and a fixed-priority arbiter from the same stimulus
//   and compares both against a transaction-level ownership model every cycle,
//   plus directed scenarios with literal expected values.
module tb_mips_bus_arbiter;

    typedef struct packed {
        logic [31:0] s_address;
        logic        s_read;
        logic        s_write;
        logic [31:0] s_writedata;
        logic [3:0]  s_byteenable;
        logic        m0_waitrequest;
        logic        m1_waitrequest;
        logic [31:0] m0_readdata;
        logic [31:0] m1_readdata;
    } outs_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] m0_address, m1_address, m0_writedata, m1_writedata, s_readdata;
    logic        m0_read, m0_write, m1_read, m1_write, s_waitrequest;
    logic [3:0]  m0_byteenable, m1_byteenable;

    logic [31:0] rr_s_address, rr_s_writedata, rr_m0_readdata, rr_m1_readdata;
    logic        rr_s_read, rr_s_write, rr_m0_waitrequest, rr_m1_waitrequest;
    logic [3:0]  rr_s_byteenable;
    logic [31:0] fp_s_address, fp_s_writedata, fp_m0_readdata, fp_m1_readdata;
    logic        fp_s_read, fp_s_write, fp_m0_waitrequest, fp_m1_waitrequest;
    logic [3:0]  fp_s_byteenable;

    outs_t act_rr, act_fp;
    int    checks = 0;
    int    failures = 0;
    // Model: current owner per DUT (-1 none, 0 m0, 1 m1) and last completed master.
    int    own[2] = '{-1, -1};
    int    lg[2]  = '{1, 1};
    logic  req0, req1, acc0, acc1;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    assign act_rr = {rr_s_address, rr_s_read, rr_s_write, rr_s_writedata, rr_s_byteenable,
                     rr_m0_waitrequest, rr_m1_waitrequest, rr_m0_readdata, rr_m1_readdata};
    assign act_fp = {fp_s_address, fp_s_read, fp_s_write, fp_s_writedata, fp_s_byteenable,
                     fp_m0_waitrequest, fp_m1_waitrequest, fp_m0_readdata, fp_m1_readdata};

    always #5 clk = ~clk;

    mips_bus_arbiter #(.ROUND_ROBIN(1)) dut_rr (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(rr_m0_waitrequest), .m0_readdata(rr_m0_readdata),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(rr_m1_waitrequest), .m1_readdata(rr_m1_readdata),
        .s_address(rr_s_address), .s_read(rr_s_read), .s_write(rr_s_write),
        .s_writedata(rr_s_writedata), .s_byteenable(rr_s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata)
    );

    mips_bus_arbiter #(.ROUND_ROBIN(0)) dut_fp (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(fp_m0_waitrequest), .m0_readdata(fp_m0_readdata),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(fp_m1_waitrequest), .m1_readdata(fp_m1_readdata),
        .s_address(fp_s_address), .s_read(fp_s_read), .s_write(fp_s_write),
        .s_writedata(fp_s_writedata), .s_byteenable(fp_s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata)
    );

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // What the bus must look like given who owns it and what the masters drive.
    function automatic outs_t expect_outs(input int owner);
        outs_t e;
        e = '0;
        e.m0_waitrequest = 1'b1;
        e.m1_waitrequest = 1'b1;
        if (owner == 0) begin
            e.s_address      = m0_address;
            e.s_write        = m0_write;
            e.s_read         = m0_read && !m0_write;
            e.s_writedata    = m0_writedata;
            e.s_byteenable   = m0_byteenable;
            e.m0_waitrequest = s_waitrequest;
            e.m0_readdata    = s_readdata;
        end else if (owner == 1) begin
            e.s_address      = m1_address;
            e.s_write        = m1_write;
            e.s_read         = m1_read && !m1_write;
            e.s_writedata    = m1_writedata;
            e.s_byteenable   = m1_byteenable;
            e.m1_waitrequest = s_waitrequest;
            e.m1_readdata    = s_readdata;
        end
        return e;
    endfunction

    // Ownership model: k=0 round-robin DUT, k=1 fixed-priority DUT.
    always @(posedge clk or posedge reset) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                own[k] <= -1;
                lg[k]  <= 1;
            end else if (own[k] < 0) begin
                if (req0 && req1)  own[k] <= (k == 0) ? 1 - lg[k] : 1;
                else if (req0)     own[k] <= 0;
                else if (req1)     own[k] <= 1;
            end else if (!((own[k] == 0) ? req0 : req1)) begin
                own[k] <= -1;
            end else if (!s_waitrequest) begin
                own[k] <= -1;
                lg[k]  <= own[k];
            end
        end
    end

    always @(negedge clk) begin
        check("rr_bus", act_rr, expect_outs(own[0]));
        check("fp_bus", act_fp, expect_outs(own[1]));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic clear_m0();
        m0_read = 0; m0_write = 0; m0_address = 0; m0_writedata = 0; m0_byteenable = 0;
    endtask

    task automatic clear_m1();
        m1_read = 0; m1_write = 0; m1_address = 0; m1_writedata = 0; m1_byteenable = 0;
    endtask

    task automatic new_req(input int m);
        int kind;
        kind = $urandom_range(0, 6);
        if (m == 0) begin
            m0_read = (kind <= 2) || (kind == 6);
            m0_write = (kind >= 3);
            m0_address = $urandom; m0_writedata = $urandom; m0_byteenable = 4'($urandom);
        end else begin
            m1_read = (kind <= 2) || (kind == 6);
            m1_write = (kind >= 3);
            m1_address = $urandom; m1_writedata = $urandom; m1_byteenable = 4'($urandom);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_m0(); clear_m1();
        s_waitrequest = 0; s_readdata = 0;
        reset = 1;
        repeat (2) tick();

        // Reset state.
        neg();
        check("rst_m0_wait", rr_m0_waitrequest, 1'b1);
        check("rst_m1_wait", rr_m1_waitrequest, 1'b1);
        check("rst_strobes", {rr_s_read, rr_s_write}, 2'b00);
        check("rst_readdata", {rr_m0_readdata, rr_m1_readdata}, 64'h0);
        tick();
        reset = 0;

        // Single read with one-cycle arbitration latency.
        tick();
        m0_read = 1; m0_address = 32'hBFC0_0000; s_readdata = 32'h3C02_1234; s_waitrequest = 0;
        neg();
        check("rd_c1_sread", rr_s_read, 1'b0);
        check("rd_c1_m0wait", rr_m0_waitrequest, 1'b1);
        tick(); neg();
        check("rd_c2_sread", rr_s_read, 1'b1);
        check("rd_c2_addr", rr_s_address, 32'hBFC0_0000);
        check("rd_c2_rdata", rr_m0_readdata, 32'h3C02_1234);
        check("rd_c2_m0wait", rr_m0_waitrequest, 1'b0);
        tick();
        clear_m0();
        neg();
        check("rd_c3_idle", rr_s_read, 1'b0);

        // Read and write together: write wins.
        tick();
        m0_read = 1; m0_write = 1; m0_address = 32'h10; m0_writedata = 32'h1234_5678; m0_byteenable = 4'hF;
        tick(); neg();
        check("rw_swrite", rr_s_write, 1'b1);
        check("rw_sread", rr_s_read, 1'b0);
        tick();
        clear_m0();

        // Tie after reset: m0 first, m0 re-requests during the idle cycle and
        // loses that tie to m1, then is served afterwards.
        reset = 1;
        tick();
        reset = 0;
        m0_read = 1; m0_address = 32'h100; m1_read = 1; m1_address = 32'h200;
        neg();
        check("tie_c1_idle", {rr_m0_waitrequest, rr_m1_waitrequest, rr_s_read}, 3'b110);
        tick(); neg();
        check("tie_c2_addr", rr_s_address, 32'h100);
        check("tie_c2_m0wait", rr_m0_waitrequest, 1'b0);
        check("fp_tie_addr", fp_s_address, 32'h200);
        tick();
        m0_address = 32'h104;
        neg();
        check("tie_c3_idle", {rr_s_read, rr_m1_waitrequest}, 2'b01);
        tick(); neg();
        check("tie_c4_addr", rr_s_address, 32'h200);
        check("tie_c4_waits", {rr_m0_waitrequest, rr_m1_waitrequest}, 2'b10);
        tick();
        clear_m1();
        tick(); neg();
        check("tie_c6_addr", rr_s_address, 32'h104);
        tick();
        clear_m0();

        // Fixed priority with both masters requesting continuously.
        tick();
        m0_read = 1; m0_address = 32'h500; m1_read = 1; m1_address = 32'h600;
        for (int i = 0; i < 16; i++) begin
            neg();
            check("fp_m0_starved", fp_m0_waitrequest, 1'b1);
            tick();
        end
        clear_m0(); clear_m1();
        repeat (2) tick();

        // Slave stall on an m1 write, with m0 arriving mid-transfer.
        m1_write = 1; m1_address = 32'h2000; m1_writedata = 32'hDEAD_BEEF; m1_byteenable = 4'b0011;
        s_waitrequest = 1;
        tick();
        for (int i = 0; i < 3; i++) begin
            neg();
            check("stall_fwd", {rr_s_write, rr_s_address, rr_s_writedata, rr_s_byteenable},
                  {1'b1, 32'h2000, 32'hDEAD_BEEF, 4'b0011});
            check("stall_waits", {rr_m0_waitrequest, rr_m1_waitrequest}, 2'b11);
            tick();
            if (i == 0) begin m0_read = 1; m0_address = 32'h300; end
            if (i == 2) s_waitrequest = 0;
        end
        neg();
        check("stall_done", {rr_s_write, rr_m1_waitrequest, rr_m0_waitrequest}, 3'b101);
        tick();
        clear_m1();
        neg();
        check("stall_idle", {rr_s_read, rr_m0_waitrequest}, 2'b01);
        tick(); neg();
        check("stall_m0_served", {rr_s_address, rr_m0_waitrequest}, {32'h300, 1'b0});
        tick();
        clear_m0();
        tick();

        // Reset in the middle of a stalled m1 transfer.
        m1_write = 1; m1_address = 32'h700; m1_writedata = 32'hCAFE_F00D; m1_byteenable = 4'hF;
        s_waitrequest = 1;
        tick(); neg();
        check("rst_mid_pre", rr_s_write, 1'b1);
        #2;
        reset = 1;
        m0_read = 1; m0_address = 32'h400;
        #1;
        check("rst_mid_swrite", rr_s_write, 1'b0);
        check("rst_mid_m1wait", rr_m1_waitrequest, 1'b1);
        tick();
        reset = 0;
        s_waitrequest = 0;
        neg();
        check("rst_rel_idle", {rr_s_read, rr_s_write}, 2'b00);
        tick(); neg();
        check("rst_rel_m0_first", {rr_s_address, rr_m0_waitrequest}, {32'h400, 1'b0});
        tick();
        clear_m0();
        repeat (3) tick();
        clear_m1();
        tick();

        // Randomized traffic, stalls, protocol violations and reset pulses.
        for (int i = 0; i < 3000; i++) begin
            neg();
            acc0 = req0 && !rr_m0_waitrequest;
            acc1 = req1 && !rr_m1_waitrequest;
            tick();
            reset = ($urandom_range(0, 399) == 0);
            if (req0) begin
                if (acc0 || $urandom_range(0, 49) == 0) clear_m0();
            end else if ($urandom_range(0, 2) == 0) begin
                new_req(0);
            end
            if (req1) begin
                if (acc1 || $urandom_range(0, 49) == 0) clear_m1();
            end else if ($urandom_range(0, 2) == 0) begin
                new_req(1);
            end
            s_waitrequest = ($urandom_range(0, 2) == 0);
            s_readdata = $urandom;
        end
        reset = 0;
        clear_m0(); clear_m1();
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_bus_arbiter.md
MIPS_BUS_ARBITER -- requirements
Module: mips_bus_arbiter

Interface
REQ-001 Parameter: ROUND_ROBIN, default 1, 1 = round-robin tie-break, 0 = fixed priority to m1 (data port).
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 m0_address/m1_address  input  32  byte address from instruction (m0) / data (m1) master.
REQ-005 m0_read/m1_read  input  1  read request, held until accepted.
REQ-006 m0_write/m1_write  input  1  write request, held until accepted.
REQ-007 m0_writedata/m1_writedata  input  32  write data.
REQ-008 m0_byteenable/m1_byteenable  input  4  byte lanes.
REQ-009 m0_waitrequest/m1_waitrequest  output  1  1 = request not accepted this cycle.
REQ-010 m0_readdata/m1_readdata  output  32  read data; valid in the accept cycle.
REQ-011 s_address  output  32  address to shared memory slave.
REQ-012 s_read, s_write  output  1 each  forwarded request strobes.
REQ-013 s_writedata  output  32; s_byteenable  output  4  forwarded write data / lanes.
REQ-014 s_waitrequest  input  1; s_readdata  input  32  slave stall / read data.

Function
REQ-015 States: ARB_IDLE, ARB_M0, ARB_M1; registered state plus a 1-bit last_grant register.
REQ-016 A master is requesting when its read or write is 1; a transfer completes on a rising edge where the owner's request is 1 and s_waitrequest is 0.
REQ-017 ARB_IDLE: if exactly one master requests, next state is that master's ARB_Mx; with no request, remain in ARB_IDLE.
REQ-018 ARB_IDLE, both requesting, ROUND_ROBIN=1: grant the master that is not last_grant; ROUND_ROBIN=0: grant m1.
REQ-019 Arbitration latency is one cycle: a request first seen in ARB_IDLE is forwarded to the slave the cycle after.
REQ-020 In ARB_Mx: the slave outputs equal master x's inputs combinationally, mx_waitrequest = s_waitrequest, and mx_readdata = s_readdata.
REQ-021 A master that does not own the bus sees waitrequest = 1 and readdata = 0, in every state including ARB_IDLE.
REQ-022 In ARB_IDLE all slave outputs are 0.
REQ-023 On completion, next state is ARB_IDLE and last_grant is set to x; the minimum gap between consecutive transfers is one idle cycle.
REQ-024 Owner drops its request before completion (protocol violation): return to ARB_IDLE next cycle, last_grant unchanged.
REQ-025 Owner asserts read and write together: forward write only; s_read = 0.
REQ-026 A new request arriving during another master's ownership waits without loss; the arbiter keeps no queue beyond the held request.

Reset
REQ-027 Assertion of reset immediately forces ARB_IDLE and last_grant = m1; all slave outputs become 0, both waitrequest outputs become 1, and both readdata outputs become 0.
REQ-028 Reset asserted mid-transfer aborts that transfer with no completion reported; the first arbitration after release is unaffected by pre-reset state.

Structure
REQ-029 Package mips_bus_pkg shall hold the arb_state_t enum and the constants ADDR_W=32, DATA_W=32, and BE_W=4.
REQ-030 One sub-module, mips_bus_rr_grant, shall be combinational next-grant logic taking the two requests, last_grant and ROUND_ROBIN.

Verification
REQ-031 Single read: m0_read, address 0xBFC00000, slave waitrequest 0 -> s_read high in cycle 2; m0_readdata = 0x3C021234 with m0_waitrequest 0 in that cycle.
REQ-032 Tie: m0 and m1 read in the same cycle after reset -> m0 served first, then m1 after one idle cycle; a second tie is served m1 first.
REQ-033 ROUND_ROBIN=0 with m0 and m1 both requesting continuously -> m1 is always granted at each arbitration.
REQ-034 Slave stall: m1_write, data 0xDEADBEEF, byteenable 4'b0011, s_waitrequest high 3 cycles -> outputs held stable, m0_waitrequest 1 throughout, completion on the 4th cycle.
REQ-035 Reset pulse while in ARB_M1 mid-stall -> s_write 0 and m1_waitrequest 1 immediately; after release, a pending m0 read is granted first.
REQ-036 Read and write asserted together by m0 -> s_write 1 and s_read 0.
